// File: rtl/mem_sorter_if.sv
// Control and data-memory port bundle for the in-place memory sorter.
// master drives start/length and returns read data; slave is the sorter.
interface mem_sorter_if;
    logic       start;
    logic [4:0] length;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;
    logic [7:0] swap_count;

    modport master (
        output start, length, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, busy, done, swap_count
    );

    modport slave (
        input  start, length, mem_rdata,
        output mem_addr, mem_wdata, mem_we, busy, done, swap_count
    );
endinterface

// File: rtl/mem_sorter.sv
// In-place ascending bubble sort (early exit) over a 16x8 memory,
// one memory access per cycle through a single read/write port.
module mem_sorter (
    input  logic         clk,
    input  logic         rst,
    mem_sorter_if.slave  sif
);
    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_B, WRITE_LO, WRITE_HI, PASS_END, DONE
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] j_q, j_d;
    logic [3:0] limit_q, limit_d;
    logic       swapped_q, swapped_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] cnt_q, cnt_d;
    logic       last_cmp;

    // j never exceeds 14, so j+1 fits in 4 bits
    assign last_cmp = (j_q + 4'd1) == limit_q;

    always_comb begin
        state_d       = state_q;
        j_d           = j_q;
        limit_d       = limit_q;
        swapped_d     = swapped_q;
        a_d           = a_q;
        b_d           = b_q;
        cnt_d         = cnt_q;
        sif.mem_addr  = 4'd0;
        sif.mem_wdata = 8'd0;
        sif.mem_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sif.start) begin
                    cnt_d = 8'd0;
                    if (sif.length < 5'd2) begin
                        state_d = DONE;
                    end else begin
                        limit_d   = sif.length[4] ? 4'd15
                                                  : sif.length[3:0] - 4'd1;
                        j_d       = 4'd0;
                        swapped_d = 1'b0;
                        state_d   = LOAD_A;
                    end
                end
            end
            LOAD_A: begin
                sif.mem_addr = j_q;
                a_d          = sif.mem_rdata;
                state_d      = LOAD_B;
            end
            LOAD_B: begin
                sif.mem_addr = j_q + 4'd1;
                b_d          = sif.mem_rdata;
                if (a_q > sif.mem_rdata) begin
                    swapped_d = 1'b1;
                    cnt_d     = cnt_q + 8'd1;
                    state_d   = WRITE_LO;
                end else if (last_cmp) begin
                    state_d = PASS_END;
                end else begin
                    j_d     = j_q + 4'd1;
                    state_d = LOAD_A;
                end
            end
            WRITE_LO: begin
                sif.mem_addr  = j_q;
                sif.mem_wdata = b_q;
                sif.mem_we    = 1'b1;
                state_d       = WRITE_HI;
            end
            WRITE_HI: begin
                sif.mem_addr  = j_q + 4'd1;
                sif.mem_wdata = a_q;
                sif.mem_we    = 1'b1;
                if (last_cmp) begin
                    state_d = PASS_END;
                end else begin
                    j_d     = j_q + 4'd1;
                    state_d = LOAD_A;
                end
            end
            PASS_END: begin
                if (!swapped_q || limit_q == 4'd1) begin
                    state_d = DONE;
                end else begin
                    limit_d   = limit_q - 4'd1;
                    j_d       = 4'd0;
                    swapped_d = 1'b0;
                    state_d   = LOAD_A;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            j_q       <= 4'd0;
            limit_q   <= 4'd0;
            swapped_q <= 1'b0;
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            limit_q   <= limit_d;
            swapped_q <= swapped_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sif.busy       = state_q != IDLE;
    assign sif.done       = state_q == DONE;
    assign sif.swap_count = cnt_q;
endmodule

// File: doc/mem_sorter.md
MEM_SORTER -- requirements
Module: mem_sorter

Interface
REQ-001 Parameters: none; address width fixed at 4 bits (16 locations), data width fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a sort; sampled only in IDLE.
REQ-005 length  input  5  element count, sampled with start; values 17..31 clamp to 16.
REQ-006 mem_addr  output  4  address to data memory port.
REQ-007 mem_wdata  output  8  write data to data memory port.
REQ-008 mem_we  output  1  write enable to data memory port; memory writes on the next rising clk edge.
REQ-009 mem_rdata  input  8  data memory read data, combinational from mem_addr (valid the same cycle).
REQ-010 busy  output  1  high while a sort is in progress, including the DONE cycle.
REQ-011 done  output  1  one-cycle pulse on completion.
REQ-012 swap_count  output  8  number of swaps in the last sort; held until the next accepted start.

Function
REQ-013 Sorts memory locations 0..len-1 ascending, unsigned, in place, bubble sort with early exit.
REQ-014 States SHALL be IDLE, LOAD_A, LOAD_B, WRITE_LO, WRITE_HI, PASS_END, DONE.
REQ-015 IDLE: on start=1, capture len=min(length,16), clear swap_count; if len<2 go to DONE, else limit=len-1, j=0, swapped=0, go to LOAD_A.
REQ-016 LOAD_A: mem_addr=j, latch a=mem_rdata, go to LOAD_B.
REQ-017 LOAD_B: mem_addr=j+1, latch b=mem_rdata; if a>b, set swapped, increment swap_count, go to WRITE_LO; else ADVANCE.
REQ-018 WRITE_LO: mem_addr=j, mem_wdata=b, mem_we=1, go to WRITE_HI.
REQ-019 WRITE_HI: mem_addr=j+1, mem_wdata=a, mem_we=1, then ADVANCE.
REQ-020 ADVANCE: if j+1==limit go to PASS_END, else j=j+1 and go to LOAD_A.
REQ-021 PASS_END: if swapped==0 or limit==1 go to DONE; else limit=limit-1, j=0, swapped=0, go to LOAD_A.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE.
REQ-023 Equal elements are never swapped (strict a>b); mem_we is high only in WRITE_LO/WRITE_HI.
REQ-024 Timing: a compare without swap takes 2 cycles, a compare with swap takes 4 cycles, PASS_END takes 1 cycle per pass.
REQ-025 start while busy is ignored; length changes while busy have no effect.
REQ-026 Outside WRITE states mem_wdata=0; in IDLE, PASS_END and DONE mem_addr=0.
REQ-027 swap_count is 8 bits; maximum reachable value is 120, so no wrap occurs.

Reset
REQ-028 rst=1 at a clock edge forces IDLE and clears busy, done, mem_we, mem_addr, mem_wdata, swap_count, j, limit, swapped, a and b to 0.
REQ-029 Reset mid-sort aborts with no further writes from that edge on; memory contents are left partially sorted and are not restored.
REQ-030 start asserted in the same cycle as rst is ignored.

Verification
REQ-031 Memory[0..8]={7,3,2,1,6,4,5,8,7}, length=9 -> memory[0..8]={1,2,3,4,5,6,7,7,8}, memory[9..15] unchanged, swap_count=12, one done pulse.
REQ-032 Memory[0..15]=0..15 ascending, length=16 -> no mem_we, swap_count=0, done high in the 32nd cycle after the start edge.
REQ-033 Memory[0..15]=15..0 descending, length=16 -> memory[i]=i, swap_count=120.
REQ-034 length=0 and length=1 -> done in the cycle after start, no writes, swap_count=0; length=20 behaves exactly as length=16.
REQ-035 start pulsed again while busy -> ignored, single done pulse; rst asserted during WRITE_LO -> mem_we=0 next cycle, busy=0, no done pulse.
